// File: rtl/dmem_port.sv
// dmem_port: memory-side responder for pipeline loads and stores.
//   Accepts one load/store per instruction in MEM, checks alignment and funct3,
//   drives a word-addressed memory handshake with byte masks and lane-replicated
//   store data, and returns the sign/zero-extended load value. The pipeline is
//   stalled while an access is outstanding.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_read/req_write          load / store request (write wins if both)
//   req_funct3/addr/wdata       access size/sign, byte address, unshifted store data
//   stall, done, fault          pipeline hold, completion pulse, error flag (with done)
//   load_data                   extended load result, held until the next completion
//   mem_read/mem_write          memory strobes, held high until mem_resp
//   mem_address/wdata/wmask     word address, replicated data, byte enables
//   mem_rdata, mem_resp         memory read data and one-cycle response
module dmem_port #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        fault_q, fault_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] cnt_q, cnt_d;

    logic        req;
    logic        req_fault;
    logic [31:0] st_wdata;
    logic [3:0]  st_wmask;
    logic [31:0] ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        busy;
    logic        timeout_hit;

    assign req  = req_read | req_write;
    assign busy = (state_q == BUSY);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST);

    // Alignment / legality check on the incoming request; write wins over read.
    always_comb begin
        req_fault = 1'b0;
        if (req_write) begin
            unique case (req_funct3)
                3'd0:    req_fault = 1'b0;
                3'd1:    req_fault = req_addr[0];
                3'd2:    req_fault = (req_addr[1:0] != 2'b00);
                default: req_fault = 1'b1;
            endcase
        end else begin
            unique case (req_funct3)
                3'd0, 3'd4: req_fault = 1'b0;
                3'd1, 3'd5: req_fault = req_addr[0];
                3'd2:       req_fault = (req_addr[1:0] != 2'b00);
                default:    req_fault = 1'b1;
            endcase
        end
    end

    // Store lanes are computed at accept time so the memory outputs come from flops.
    always_comb begin
        st_wdata = 32'h0;
        st_wmask = 4'h0;
        if (req_write) begin
            unique case (req_funct3[1:0])
                2'd0: begin
                    st_wdata = {4{req_wdata[7:0]}};
                    st_wmask = 4'b0001 << req_addr[1:0];
                end
                2'd1: begin
                    st_wdata = {2{req_wdata[15:0]}};
                    st_wmask = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_wdata = req_wdata;
                    st_wmask = 4'b1111;
                end
            endcase
        end
    end

    // Load extraction; funct3[2] selects zero extension.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (funct3_q[1:0])
            2'd0:    ld_ext = {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte};
            2'd1:    ld_ext = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        fault_d     = fault_q;
        load_data_d = load_data_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    write_d  = req_write;
                    wdata_d  = st_wdata;
                    wmask_d  = st_wmask;
                    cnt_d    = 32'h0;
                    if (req_fault) begin
                        state_d     = DONE;
                        fault_d     = 1'b1;
                        load_data_d = 32'h0;
                    end else begin
                        state_d = BUSY;
                        fault_d = 1'b0;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_resp) begin
                    state_d     = DONE;
                    fault_d     = 1'b0;
                    load_data_d = write_q ? 32'h0 : ld_ext;
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    fault_d     = 1'b1;
                    load_data_d = 32'h0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            funct3_q    <= 3'h0;
            write_q     <= 1'b0;
            wdata_q     <= 32'h0;
            wmask_q     <= 4'h0;
            fault_q     <= 1'b0;
            load_data_q <= 32'h0;
            cnt_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
            cnt_q       <= cnt_d;
        end
    end

    // stall is combinational on the request so the accept cycle holds upstream.
    assign stall       = ((state_q == IDLE) && req) || busy;
    assign done        = (state_q == DONE);
    assign fault       = done & fault_q;
    assign load_data   = load_data_q;
    assign mem_read    = busy & ~write_q;
    assign mem_write   = busy & write_q;
    assign mem_address = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata   = busy ? wdata_q : 32'h0;
    assign mem_wmask   = busy ? wmask_q : 4'h0;

endmodule

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Memory-side responder for the load/store requests the decode stage's control word raises (dmem_read / dmem_write with funct3).
- Accepts one request per instruction in the MEM stage and checks alignment.
- Drives a word-addressed memory handshake (read/write, resp) with byte masks and lane-shifted store data.
- Returns the sign- or zero-extended load value, and stalls the pipeline while the access is outstanding.

Parameters:
TIMEOUT, 255, cycles in BUSY without mem_resp before the access is aborted as a fault; 0 disables the timeout.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
req_read  in  1  load request (control word dmem_read).
req_write  in  1  store request (control word dmem_write).
req_funct3  in  3  load/store funct3 (lb=0, lh=1, lw=2, lbu=4, lhu=5; sb=0, sh=1, sw=2).
req_addr  in  32  byte address (ALU output).
req_wdata  in  32  store data (rs2 value, unshifted).
stall  out  1  hold upstream pipeline registers.
done  out  1  one-cycle completion pulse.
fault  out  1  valid with done; misaligned, illegal funct3, or timeout.
load_data  out  32  extended load result; valid with done and no fault.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
mem_address  out  32  word-aligned address, {addr[31:2],2'b00}.
mem_wdata  out  32  lane-replicated store data.
mem_wmask  out  4  byte-enable mask.
mem_rdata  in  32  memory read data.
mem_resp  in  1  memory response, one-cycle pulse.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, captured request, timeout counter and load_data cleared. Reset while BUSY aborts the access immediately: mem_read/mem_write fall without waiting for mem_resp, and no done is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Request = req_read | req_write. If both are asserted, write wins and the read is ignored.
  - When a request is present, stall=1 combinationally in that cycle, and addr, funct3, kind and wdata are registered.
  - Fault check: halfword with addr[0]=1, word with addr[1:0]!=0, load funct3 in {3,6,7}, or store funct3 >=3. On fault → DONE with fault=1; no memory access is made.
  - Otherwise → BUSY.
- BUSY:
  - mem_read or mem_write is held at 1, together with mem_address, mem_wdata and mem_wmask, all stable from registers. stall=1. The counter increments each cycle.
  - mem_resp=1 → capture the extended load data, drop the strobes at that edge, go to DONE.
  - counter==TIMEOUT-1 with no resp (TIMEOUT>0) → drop the strobes, load_data=0, fault=1, go to DONE.
  - A mem_resp arriving in any state other than BUSY is ignored.
- DONE: done=1 and stall=0 for exactly one cycle. No new request is accepted in this cycle. → IDLE.
- Minimum latency: accept cycle (IDLE), 1 BUSY cycle with resp, done in cycle 3.
- Store lanes:
  - sb: wdata[7:0] replicated to all 4 bytes; mask = 4'b0001<<addr[1:0].
  - sh: wdata[15:0] replicated to both halves; mask 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - sw: wdata as-is; mask 1111.
  - mem_wmask=0 and mem_wdata=0 during loads.
- Load extraction from mem_rdata:
  - lb/lbu select byte addr[1:0], sign/zero-extended.
  - lh/lhu select half addr[1], sign/zero-extended.
  - lw passes mem_rdata through.
- load_data holds its value until the next DONE. It is 0 after a store or a fault.
- The counter clears on every entry to BUSY.

Test Plan:
- lw at 0x1000_0008, mem_resp on 1st BUSY cycle with rdata=0xDEAD_BEEF → mem_address=0x1000_0008, mem_read for 1 cycle, done in cycle 3, load_data=0xDEAD_BEEF, fault=0.
- lb at 0x...03 and lbu at 0x...03, rdata=0x80FF_7F01 → lb gives 0xFFFF_FF80; lbu gives 0x0000_0080. lh at 0x...02 → 0xFFFF_80FF.
- sb at 0x2001, wdata=0x1234_56AB → mem_wmask=0010, mem_wdata=0xABAB_ABAB. sh at 0x2002, wdata=0x0000_BEEF → mask 1100, mem_wdata=0xBEEF_BEEF.
- lw at 0x...02, and sh at 0x...01 → no mem_read/mem_write at any cycle; done=1 and fault=1 in cycle 2.
- TIMEOUT=4, load with mem_resp never asserted → mem_read high for exactly 4 cycles, then done=1, fault=1, load_data=0. A late mem_resp after that is ignored.
- Assert rst=0 on the 2nd BUSY cycle of a store → mem_write falls asynchronously, no done. After release, the next lw completes normally. Also: req_read and req_write both high → a store is issued.
